// File: rtl/kbdmus_spi_loader.sv
// Assembles the AVR SPI byte stream into the 40-bit key matrix and the
// mouse / Kempston bytes, each published with a one-cycle strobe.
module kbdmus_spi_loader #(
  parameter logic [7:0] KBD_ADDR    = 8'h10,
  parameter logic [7:0] MUSX_ADDR   = 8'h20,
  parameter logic [7:0] MUSY_ADDR   = 8'h21,
  parameter logic [7:0] MUSBTN_ADDR = 8'h22,
  parameter logic [7:0] KJ_ADDR     = 8'h23
) (
  input  logic        fclk,
  input  logic        rst,
  input  logic        spi_start,
  input  logic [7:0]  spi_addr,
  input  logic        spi_valid,
  input  logic [7:0]  spi_data,
  input  logic        spi_end,
  output logic [39:0] kbd_out,
  output logic        kbd_stb,
  output logic [7:0]  mus_out,
  output logic        mus_xstb,
  output logic        mus_ystb,
  output logic        mus_btnstb,
  output logic        kj_stb,
  output logic        frame_err,
  output logic [1:0]  fsm_state
);

  // Handshake: spi_start, spi_valid and spi_end are single-cycle pulses with
  // no backpressure; every output strobe is registered and lasts one cycle.
  typedef enum logic [1:0] {ST_IDLE, ST_KBD, ST_MUS, ST_SKIP} state_t;

  state_t      state_q, state_n;
  logic [2:0]  cnt_q, cnt_n;
  logic [39:0] stage_q, stage_n;
  logic [1:0]  tgt_q, tgt_n;
  logic [39:0] kbd_n;
  logic [7:0]  mus_n;
  logic        kstb_q, kstb_n;
  logic [3:0]  mstb_q, mstb_n;
  logic        ferr_q, ferr_n;

  always_ff @(posedge fclk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      stage_q <= 40'd0;
      tgt_q   <= 2'd0;
      kbd_out <= 40'd0;
      mus_out <= 8'd0;
      kstb_q  <= 1'b0;
      mstb_q  <= 4'd0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      stage_q <= stage_n;
      tgt_q   <= tgt_n;
      kbd_out <= kbd_n;
      mus_out <= mus_n;
      kstb_q  <= kstb_n;
      mstb_q  <= mstb_n;
      ferr_q  <= ferr_n;
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    stage_n = stage_q;
    tgt_n   = tgt_q;
    kbd_n   = kbd_out;
    mus_n   = mus_out;
    kstb_n  = 1'b0;
    mstb_n  = 4'd0;
    ferr_n  = 1'b0;
    if (spi_start) begin
      // The address phase owns this cycle; a coincident data byte is dropped.
      ferr_n = (state_q == ST_KBD) && (cnt_q != 3'd0);
      if (spi_addr == KBD_ADDR) begin
        state_n = ST_KBD;
        cnt_n   = 3'd0;
        stage_n = 40'd0;
      end else if (spi_addr == MUSX_ADDR) begin
        state_n = ST_MUS;
        tgt_n   = 2'd0;
      end else if (spi_addr == MUSY_ADDR) begin
        state_n = ST_MUS;
        tgt_n   = 2'd1;
      end else if (spi_addr == MUSBTN_ADDR) begin
        state_n = ST_MUS;
        tgt_n   = 2'd2;
      end else if (spi_addr == KJ_ADDR) begin
        state_n = ST_MUS;
        tgt_n   = 2'd3;
      end else begin
        state_n = ST_SKIP;
      end
    end else begin
      case (state_q)
        ST_KBD: begin
          if (spi_valid) begin
            if (cnt_q >= 3'd5) begin
              state_n = ST_SKIP;
              cnt_n   = 3'd6;
              ferr_n  = 1'b1;
            end else begin
              stage_n = {stage_q[31:0], spi_data};
              cnt_n   = cnt_q + 3'd1;
            end
          end
          // End is judged on the count including a byte in this same cycle.
          if (spi_end) begin
            state_n = ST_IDLE;
            if (cnt_n == 3'd5) begin
              kbd_n  = stage_n;
              kstb_n = 1'b1;
            end else if (cnt_n != 3'd0 && cnt_n != 3'd6) begin
              ferr_n = 1'b1;
            end
          end
        end
        ST_MUS: begin
          if (spi_valid) begin
            mus_n         = spi_data;
            mstb_n[tgt_q] = 1'b1;
          end
          if (spi_end) state_n = ST_IDLE;
        end
        ST_SKIP: begin
          if (spi_end) state_n = ST_IDLE;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  assign kbd_stb    = kstb_q;
  assign mus_xstb   = mstb_q[0];
  assign mus_ystb   = mstb_q[1];
  assign mus_btnstb = mstb_q[2];
  assign kj_stb     = mstb_q[3];
  assign frame_err  = ferr_q;
  assign fsm_state  = state_q;

endmodule
